// File: rtl/bcd_serial_addsub_ctrl_pkg.sv
// Shared definitions for the serial BCD add/sub sequencer.
//   state_e     : sequencer states (IDLE, RUN, DONE)
//   BCD_W       : bits per BCD digit
//   MAX_DIGIT   : largest legal BCD digit value
//   CORRECTION  : value added to a binary digit sum above 9 to wrap it into BCD
package bcd_serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int                BCD_W      = 4;
    localparam logic [BCD_W-1:0]  MAX_DIGIT  = 4'd9;
    localparam logic [BCD_W-1:0]  CORRECTION = 4'd6;

endpackage

// File: rtl/bcd_serial_addsub_ctrl_if.sv
// Requester-side bus of the serial BCD add/sub sequencer.
//   start/op/a/b          : request strobe, operation select, packed BCD operands
//   busy/done             : status, one-cycle completion pulse
//   result/cout/err       : packed BCD result, carry / sign flag, bad-digit flag
// master = requester, slave = sequencer.
interface bcd_serial_addsub_ctrl_if
    import bcd_serial_addsub_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                    start;
    logic                    op;
    logic [BCD_W*DIGITS-1:0] a;
    logic [BCD_W*DIGITS-1:0] b;
    logic                    busy;
    logic                    done;
    logic [BCD_W*DIGITS-1:0] result;
    logic                    cout;
    logic                    err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, err
    );
endinterface

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder.
//   x, y : BCD digits (0..9)
//   cin  : decimal carry in
//   sum  : corrected BCD sum digit
//   cout : decimal carry out
module bcd_digit_adder
    import bcd_serial_addsub_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);
    logic [BCD_W:0] s;

    assign s = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};

    // Adding 6 modulo 16 skips the six unused binary codes 10..15.
    always_comb begin
        if (s > {1'b0, MAX_DIGIT}) begin
            sum  = s[BCD_W-1:0] + CORRECTION;
            cout = 1'b1;
        end else begin
            sum  = s[BCD_W-1:0];
            cout = 1'b0;
        end
    end
endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// Multi-digit packed-BCD add/subtract sequencer. One digit adder is reused
// least-significant digit first, one digit per clock. Subtraction is done as
// A + nines_complement(B) + 1, so the final carry is 1 when A >= B.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bcd_serial_addsub_ctrl_if (request + result)
module bcd_serial_addsub_ctrl
    import bcd_serial_addsub_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    bcd_serial_addsub_ctrl_if.slave  bus
);
    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               any_bad;
    logic [W-1:0]       b_nines;
    logic [BCD_W-1:0]   dig_x, dig_y, dig_sum;
    logic               dig_cout;

    // Screen incoming operands and pre-compute the nine's complement of B.
    always_comb begin
        any_bad = 1'b0;
        b_nines = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.a[i*BCD_W +: BCD_W] > MAX_DIGIT || bus.b[i*BCD_W +: BCD_W] > MAX_DIGIT)
                any_bad = 1'b1;
            b_nines[i*BCD_W +: BCD_W] = MAX_DIGIT - bus.b[i*BCD_W +: BCD_W];
        end
    end

    assign dig_x = a_q[int'(idx_q)*BCD_W +: BCD_W];
    assign dig_y = b_q[int'(idx_q)*BCD_W +: BCD_W];

    bcd_digit_adder u_digit_adder (
        .x    (dig_x),
        .y    (dig_y),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE)
                    state_d = ST_IDLE;
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.op ? b_nines : bus.b;
                    carry_d  = bus.op;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    err_d    = 1'b0;
                    if (any_bad) begin
                        // Bad digit: finish at once, result stays 0.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                result_d[int'(idx_q)*BCD_W +: BCD_W] = dig_sum;
                carry_d = dig_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    cout_d  = dig_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Self-checking bench for bcd_serial_addsub_ctrl: directed cases, protocol
// cases, mid-run reset and randomized operations checked against a decimal
// arithmetic reference model.
module tb_bcd_serial_addsub_ctrl;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_serial_addsub_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_addsub_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic longint bcd_val(input logic [W-1:0] v);
        longint r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint n);
        logic [W-1:0] r = '0;
        longint m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] a, input logic [W-1:0] b);
        bit bad = 0;
        for (int i = 0; i < DIGITS; i++)
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) bad = 1;
        return bad;
    endfunction

    task automatic model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output bit c, output bit e);
        longint lim = 1;
        longint av, bv;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        av = bcd_val(a);
        bv = bcd_val(b);
        if (has_bad(a, b)) begin
            r = '0; c = 0; e = 1;
        end else if (!op) begin
            r = to_bcd((av + bv) % lim); c = (av + bv) >= lim; e = 0;
        end else if (av >= bv) begin
            r = to_bcd(av - bv); c = 1; e = 0;
        end else begin
            r = to_bcd(lim + av - bv); c = 0; e = 0;
        end
    endtask

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) begin
            v[i*4 +: 4] = 4'($urandom_range(0, 9));
            if (allow_bad && $urandom_range(0, 11) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic launch(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Called at the negedge where start was driven. Waits for done (bounded),
    // checks latency, busy, and outputs. If chain=1 it returns at the done
    // cycle so the caller can hold start for a back-to-back request.
    task automatic finish_op(input string tag, input logic [W-1:0] exp_r, input bit exp_c,
                             input bit exp_e, input bit intrude, input bit chain);
        int cnt = 0;
        bit busy_bad = 0;
        int exp_lat = exp_e ? 1 : DIGITS + 1;
        do begin
            @(negedge clk);
            cnt++;
            bus.start = 1'b0;
            if (intrude && cnt == 2) begin
                launch(1'($urandom_range(0, 1)), rand_bcd(0), rand_bcd(0));
            end
            if (!bus.done && bus.busy !== 1'b1) busy_bad = 1;
        end while (!bus.done && cnt < 20);
        check({tag, "_latency"}, 64'(cnt), 64'(exp_lat));
        check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_result"}, 64'(bus.result), 64'(exp_r));
        check({tag, "_cout"}, 64'(bus.cout), 64'(exp_c));
        check({tag, "_err"}, 64'(bus.err), 64'(exp_e));
        if (!chain) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
            check({tag, "_result_held"}, 64'(bus.result), 64'(exp_r));
        end
    endtask

    // Watchdog: the bench must end on its own even if the DUT stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, er;
        bit rop, ec, ee, chain, intrude, rst_done_bad;

        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",   64'(bus.busy),   64'd0);
        check("rst_done",   64'(bus.done),   64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_cout",   64'(bus.cout),   64'd0);
        check("rst_err",    64'(bus.err),    64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived expectations
        launch(0, 16'h0458, 16'h0367); finish_op("add",      16'h0825, 0, 0, 0, 0);
        launch(0, 16'h9999, 16'h0001); finish_op("add_ovf",  16'h0000, 1, 0, 0, 0);
        launch(1, 16'h0825, 16'h0367); finish_op("sub_pos",  16'h0458, 1, 0, 0, 0);
        launch(1, 16'h0367, 16'h0825); finish_op("sub_neg",  16'h9542, 0, 0, 0, 0);
        launch(0, 16'h00A1, 16'h0001); finish_op("bad_dig",  16'h0000, 0, 1, 0, 0);

        // Start during RUN is ignored
        launch(0, 16'h0458, 16'h0367); finish_op("ignore",   16'h0825, 0, 0, 1, 0);

        // Back-to-back: start held during done, next op has no idle cycle
        launch(1, 16'h0825, 16'h0367); finish_op("b2b_1",    16'h0458, 1, 0, 0, 1);
        launch(0, 16'h9999, 16'h0001); finish_op("b2b_2",    16'h0000, 1, 0, 0, 0);

        // Reset asserted during the second RUN cycle
        launch(0, 16'h0458, 16'h0367);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   64'(bus.busy),   64'd0);
        check("midrst_done",   64'(bus.done),   64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);
        check("midrst_cout",   64'(bus.cout),   64'd0);
        check("midrst_err",    64'(bus.err),    64'd0);
        rst_done_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) rst_done_bad = 1;
        end
        rst_n = 1'b1;
        repeat (DIGITS + 2) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) rst_done_bad = 1;
        end
        check("midrst_no_done", 64'(rst_done_bad), 64'd0);
        launch(1, 16'h0367, 16'h0825); finish_op("post_rst", 16'h9542, 0, 0, 0, 0);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = rand_bcd(1);
            rb  = rand_bcd(1);
            model(rop, ra, rb, er, ec, ee);
            intrude = !ee && ($urandom_range(0, 3) == 0);
            chain   = ($urandom_range(0, 2) == 0) && (n != 39);
            launch(rop, ra, rb);
            finish_op("rand", er, ec, ee, intrude, chain);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bcd_serial_addsub_ctrl.md
# bcd_serial_addsub_ctrl

Sequencer that performs multi-digit packed-BCD addition and subtraction by time-multiplexing one single-digit BCD adder, least-significant digit first, one digit per clock. It sits between a requester that supplies two DIGITS-wide BCD operands with a start strobe and the single-digit BCD add/sub datapath. It owns operand capture, nine's-complement conversion for subtraction, carry chaining between digits, result assembly and completion signalling.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4·DIGITS bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; accepted only when busy=0.
- op  input  1  0 = add (a+b), 1 = subtract (a−b); sampled with start.
- a  input  4·DIGITS  packed BCD operand A, digit 0 in bits [3:0]; sampled with start.
- b  input  4·DIGITS  packed BCD operand B; sampled with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle completion pulse.
- result  output  4·DIGITS  packed BCD result; held from done until the next accepted start.
- cout  output  1  add: decimal carry out of top digit; subtract: 1 = result ≥ 0, 0 = negative, result in ten's-complement form.
- err  output  1  set with done when any input digit was > 9; held with result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start: latch a; latch b (op=0) or per-digit nine's complement 9−b[i] (op=1); carry ← op; digit index ← 0; result ← 0; err ← 0. Go to RUN, or to DONE directly if any a or b digit > 9.
- Invalid input: err=1, result=0, cout=0, no RUN cycles.
- RUN: present digit[idx] of A, B' and carry to the digit adder; write corrected sum into result digit idx; carry ← digit cout; idx increments. After digit DIGITS−1: cout ← final carry, go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE unless start is high, in which case accept it (back-to-back).
- Digit adder: binary sum s = x+y+cin (5 bits); if s > 9, sum = s+6 (low 4 bits), cout=1; else sum = s, cout=0.
- start while busy=1: ignored, no effect on operands or state.
- Outputs change only on clock edges or reset.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, busy=0, done=0, result=0, cout=0, err=0, idx=0, internal registers 0.
- Reset asserted mid-RUN aborts the operation immediately; no done pulse is produced.
- Start accepted at edge k → busy=1 from k through k+DIGITS; done=1 in the cycle after edge k+DIGITS. Latency start→done: DIGITS+1 cycles.
- Invalid-digit start at edge k → done=1 after edge k, busy stays 0.
- Back-to-back: start high during done → next busy begins the following cycle; throughput is one operation per DIGITS+1 cycles.
- result/cout/err are stable and valid whenever done=1 and remain stable until the next accepted start.

## Structure
- Shared package: state encoding (IDLE, RUN, DONE), BCD digit width constant (4), max-digit constant (9), correction constant (6).
- Sub-module: bcd_digit_adder, combinational one-digit adder (x, y, cin → sum, cout) instantiated once.
- Index counter width: $clog2(DIGITS), minimum 1 bit.

## Test plan
- Add: DIGITS=4, op=0, a=0x0458, b=0x0367 → done after 5 cycles, result=0x0825, cout=0, err=0.
- Add overflow: a=0x9999, b=0x0001 → result=0x0000, cout=1; carry propagates through all four digits.
- Subtract: op=1, a=0x0825, b=0x0367 → result=0x0458, cout=1; then a=0x0367, b=0x0825 → result=0x9542, cout=0.
- Invalid digit: a=0x00A1, b=0x0001 → done on the cycle after start, err=1, result=0x0000, cout=0, busy never high.
- Protocol: start pulsed again during RUN with different operands → ignored, first result unchanged; start held during done → second operation begins with no idle cycle.
- Reset: rst_n low during the 2nd RUN cycle → all outputs 0 immediately, no done; a fresh start after release produces correct result.
